// File: rtl/shmem_dma_pkg.sv
// Shared constants for the shmem_dma block: default widths and FSM state encoding.
package shmem_dma_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 13;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_READ   = 2'd1;
  localparam logic [1:0] ST_WRITE  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/shmem_if.sv
// Single shmemif access port: request/write/address/data held until a one-cycle done.
interface shmem_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  request;
  logic                  wren;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] datain;
  logic [DATA_WIDTH-1:0] dataout;
  logic                  done;

  modport master (
    output request, wren, addr, datain,
    input  dataout, done
  );

  modport slave (
    input  request, wren, addr, datain,
    output dataout, done
  );
endinterface

// File: rtl/shmem_dma.sv
// Word-by-word memory-to-memory copy engine over one shmemif port, with abort and
// length-zero handling. All outputs come straight from flops.
module shmem_dma
  import shmem_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_src,
  input  logic [ADDR_WIDTH-1:0] cfg_dst,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  xfer_count,
  shmem_if.master               shmem
);

  logic [1:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] src_q,     src_d;
  logic [ADDR_WIDTH-1:0] dst_q,     dst_d;
  logic [LEN_WIDTH-1:0]  len_q,     len_d;
  logic [LEN_WIDTH-1:0]  idx_q,     idx_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  abort_q,   abort_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  aborted_q, aborted_d;
  logic [LEN_WIDTH-1:0]  xfer_q,    xfer_d;
  logic                  req_q,     req_d;
  logic                  wren_q,    wren_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic                  abort_pend_s;
  logic [LEN_WIDTH-1:0]  idx_next_s;

  // Next-state logic for the copy FSM and its datapath registers.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    idx_d     = idx_q;
    data_d    = data_q;
    abort_d   = abort_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    xfer_d    = xfer_q;
    req_d     = req_q;
    wren_d    = wren_q;
    addr_d    = addr_q;
    // A same-cycle abort counts as pending so the completing access can honour it.
    abort_pend_s = abort_q | cfg_abort;
    idx_next_s   = idx_q + LEN_WIDTH'(1);

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (cfg_start) begin
          src_d     = cfg_src;
          dst_d     = cfg_dst;
          len_d     = cfg_len;
          idx_d     = {LEN_WIDTH{1'b0}};
          xfer_d    = {LEN_WIDTH{1'b0}};
          busy_d    = 1'b1;
          aborted_d = 1'b0;
          if (cfg_len != {LEN_WIDTH{1'b0}}) begin
            state_d = ST_READ;
            req_d   = 1'b1;
            wren_d  = 1'b0;
            addr_d  = cfg_src;
          end else begin
            state_d = ST_FINISH;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        abort_d = abort_pend_s;
        if (shmem.done) begin
          if (abort_pend_s) begin
            state_d = ST_FINISH;
            req_d   = 1'b0;
            wren_d  = 1'b0;
          end else begin
            state_d = ST_WRITE;
            wren_d  = 1'b1;
            addr_d  = dst_q + idx_q[ADDR_WIDTH-1:0];
            data_d  = shmem.dataout;
          end
        end else begin
          state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        abort_d = abort_pend_s;
        if (shmem.done) begin
          idx_d  = idx_next_s;
          xfer_d = xfer_q + LEN_WIDTH'(1);
          if ((idx_next_s == len_q) || abort_pend_s) begin
            state_d = ST_FINISH;
            req_d   = 1'b0;
            wren_d  = 1'b0;
          end else begin
            state_d = ST_READ;
            wren_d  = 1'b0;
            addr_d  = src_q + idx_next_s[ADDR_WIDTH-1:0];
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_FINISH: begin
        state_d   = ST_IDLE;
        abort_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        // Only an early stop leaves the count short of the requested length.
        aborted_d = (xfer_q != len_q);
      end

      default: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
        busy_d  = 1'b0;
        req_d   = 1'b0;
        wren_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      src_q     <= {ADDR_WIDTH{1'b0}};
      dst_q     <= {ADDR_WIDTH{1'b0}};
      len_q     <= {LEN_WIDTH{1'b0}};
      idx_q     <= {LEN_WIDTH{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      xfer_q    <= {LEN_WIDTH{1'b0}};
      req_q     <= 1'b0;
      wren_q    <= 1'b0;
      addr_q    <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      xfer_q    <= xfer_d;
      req_q     <= req_d;
      wren_q    <= wren_d;
      addr_q    <= addr_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign xfer_count    = xfer_q;
  assign shmem.request = req_q;
  assign shmem.wren    = wren_q;
  assign shmem.addr    = addr_q;
  assign shmem.datain  = data_q;

endmodule

// File: tb/tb_shmem_dma.sv
// Randomized bench for shmem_dma: behavioural memory with random access latency and
// a reference copy model computed directly from src/dst/len/abort point.
module tb_shmem_dma;
  import shmem_dma_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int LW = 13;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          srst;
  logic          cfg_start;
  logic [AW-1:0] cfg_src;
  logic [AW-1:0] cfg_dst;
  logic [LW-1:0] cfg_len;
  logic          cfg_abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] xfer_count;

  shmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  shmem_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .srst       (srst),
    .cfg_start  (cfg_start),
    .cfg_src    (cfg_src),
    .cfg_dst    (cfg_dst),
    .cfg_len    (cfg_len),
    .cfg_abort  (cfg_abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .xfer_count (xfer_count),
    .shmem      (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem      [DEPTH];
  logic [DW-1:0] load_img [DEPTH];
  logic [DW-1:0] ref_mem  [DEPTH];
  logic          load_req = 1'b0;
  logic          pend;
  logic          mdone;
  logic [AW-1:0] p_addr;
  logic          p_wren;
  logic [DW-1:0] p_din;
  logic [DW-1:0] mdout;
  int            lat_cnt;
  int            max_lat = 2;

  assign bus.done    = mdone;
  assign bus.dataout = mdout;

  // Memory responder: latches a request, waits a random latency, then completes it.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= load_img[i];
    end
    if (srst) begin
      pend    <= 1'b0;
      mdone   <= 1'b0;
      mdout   <= '0;
      lat_cnt <= 0;
    end else begin
      mdone <= 1'b0;
      if (pend) begin
        if (lat_cnt == 0) begin
          pend  <= 1'b0;
          mdone <= 1'b1;
          if (p_wren) mem[p_addr] <= p_din;
          else        mdout <= mem[p_addr];
        end else begin
          lat_cnt <= lat_cnt - 1;
        end
      end else if (bus.request && !mdone) begin
        pend    <= 1'b1;
        p_addr  <= bus.addr;
        p_wren  <= bus.wren;
        p_din   <= bus.datain;
        lat_cnt <= int'($urandom_range(max_lat, 0));
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) load_img[i] = $urandom;
  endtask

  // Runs one transfer; abort_at >= 0 raises cfg_abort while the read of that index is in flight.
  task automatic run_xfer(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input logic [LW-1:0] len, input int abort_at, input string tag);
    int ncopy, done_cnt, done_cyc, reads, quiet, cyc, diffs;
    logic req_seen, exp_ab;
    exp_ab = (abort_at >= 0) && (abort_at < int'(len));
    ncopy  = exp_ab ? abort_at : int'(len);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = load_img[i];
    for (int i = 0; i < ncopy; i++)
      ref_mem[(int'(dst) + i) % DEPTH] = ref_mem[(int'(src) + i) % DEPTH];

    @(negedge clk);
    cfg_src = src; cfg_dst = dst; cfg_len = len; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    check_eq({tag, "_busy_start"}, 64'(busy), 64'd1);

    done_cnt = 0; done_cyc = -1; reads = 0; quiet = 0; cyc = 1; req_seen = 1'b0;
    while (cyc < 3000 && quiet < 4) begin
      if (bus.request) req_seen = 1'b1;
      if (pend)
        check_eq({tag, "_hold"}, 64'({bus.request, bus.wren, bus.addr, bus.datain}),
                 64'({1'b1, p_wren, p_addr, p_din}));
      if (mdone && !bus.wren) reads++;
      if (exp_ab && reads == abort_at && bus.request && !bus.wren && !mdone) cfg_abort = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check_eq({tag, "_aborted"}, 64'(aborted), 64'(exp_ab));
        check_eq({tag, "_count"}, 64'(xfer_count), 64'(ncopy));
        check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
      end
      if (done_cyc >= 0) quiet++;
      @(negedge clk);
      cyc++;
    end
    cfg_abort = 1'b0;
    check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check_eq({tag, "_count_held"}, 64'(xfer_count), 64'(ncopy));
    if (len == '0) begin
      check_eq({tag, "_len0_lat"}, 64'(done_cyc), 64'd2);
      check_eq({tag, "_len0_noreq"}, 64'(req_seen), 64'd0);
    end
    diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check_eq({tag, "_mem"}, 64'(diffs), 64'd0);
  endtask

  initial begin
    int len_r, ab;
    srst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",    64'(busy),        64'd0);
    check_eq("rst_done",    64'(done),        64'd0);
    check_eq("rst_aborted", 64'(aborted),     64'd0);
    check_eq("rst_count",   64'(xfer_count),  64'd0);
    check_eq("rst_bus",     64'({bus.request, bus.wren, bus.addr, bus.datain}), 64'd0);
    srst = 1'b0;

    fill_random();
    for (int i = 0; i < 16; i++) load_img[i] = DW'(100 + i);
    load_mem();
    run_xfer(12'd0, 12'd2048, 13'd16, -1, "basic16");

    fill_random(); load_mem();
    run_xfer(12'd5, 12'd100, 13'd0, -1, "len0");

    fill_random(); load_mem();
    run_xfer(12'd4094, 12'd10, 13'd4, -1, "wrap");

    fill_random(); load_mem();
    run_xfer(12'h100, 12'h300, 13'd16, 2, "abort3rd");

    // Second start while busy must be ignored, then a reset mid-transfer.
    fill_random(); load_mem();
    @(negedge clk);
    cfg_src = 12'd0; cfg_dst = 12'd2048; cfg_len = 13'd16; cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    repeat (5) @(negedge clk);
    cfg_src = 12'd500; cfg_dst = 12'd600; cfg_len = 13'd3; cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.request && !bus.wren)
        check_eq("restart_ignored", 64'(bus.addr < 12'd16), 64'd1);
      @(negedge clk);
    end
    check_eq("busy_pre_srst", 64'(busy), 64'd1);
    srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    check_eq("srst_req",  64'(bus.request), 64'd0);
    check_eq("srst_busy", 64'(busy),        64'd0);
    for (int c = 0; c < 6; c++) begin
      check_eq("srst_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end

    for (int t = 0; t < 40; t++) begin
      max_lat = int'($urandom_range(3, 0));
      len_r   = int'($urandom_range(40, 0));
      ab      = (len_r > 0 && $urandom_range(3, 0) == 0) ? int'($urandom_range(len_r - 1, 0)) : -1;
      fill_random(); load_mem();
      run_xfer(AW'($urandom), AW'($urandom), LW'(len_r), ab, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
